// File: rtl/tape_controller_pkg.sv
// Shared types for the tape data path: command opcodes, controller states, default widths.
package tape_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        OP_INC   = 3'd0,
        OP_DEC   = 3'd1,
        OP_RIGHT = 3'd2,
        OP_LEFT  = 3'd3,
        OP_OUT   = 3'd4,
        OP_IN    = 3'd5,
        OP_NOP   = 3'd6,
        OP_CLR   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WAIT_OUT = 2'd2,
        ST_WAIT_IN  = 2'd3
    } state_e;

endpackage

// File: rtl/tape_controller_if.sv
// Command handshake plus byte in/out streams between the sequencer side and the tape controller.
interface tape_controller_if
    import tape_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    op_e               cmd_op;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output cmd_valid, cmd_op, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  cmd_valid, cmd_op, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/tape_controller.sv
// Data-side tape initiator: executes + - > < . , NOP and clear-cell, zero-fills the tape after reset.
// Latency: arithmetic/pointer commands 1 cycle; . and , wait for their stream handshake.
// Backpressure: cmd_ready low while clearing or waiting on out_ready / in_valid.
module tape_controller
    import tape_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    tape_controller_if.slave  cmd_if,
    output logic              busy,
    output logic [ADDR_W-1:0] ptr,
    output logic              cell_zero,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_datain,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_out
);

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_e            r_state,   w_state_nxt;
    logic [ADDR_W-1:0] r_ptr,     w_ptr_nxt;
    logic [ADDR_W-1:0] r_cnt,     w_cnt_nxt;
    logic              r_out_vld, w_out_vld_nxt;
    logic [DATA_W-1:0] r_out_dat, w_out_dat_nxt;
    logic              r_in_rdy,  w_in_rdy_nxt;

    logic              w_load;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_cmd_rdy;
    logic              w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RST_STATE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_in_rdy  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_out_vld <= w_out_vld_nxt;
            r_out_dat <= w_out_dat_nxt;
            r_in_rdy  <= w_in_rdy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_out_vld_nxt = r_out_vld;
        w_out_dat_nxt = r_out_dat;
        w_in_rdy_nxt  = r_in_rdy;
        w_load        = 1'b0;
        w_waddr       = r_ptr;
        w_wdata       = '0;
        w_cmd_rdy     = 1'b0;
        w_busy        = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                w_busy    = 1'b1;
                w_load    = 1'b1;
                w_waddr   = r_cnt;
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_cmd_rdy = 1'b1;
                if (cmd_if.cmd_valid) begin
                    // Memory read is combinational, so INC/DEC are a same-cycle read-modify-write.
                    case (cmd_if.cmd_op)
                        OP_INC: begin
                            w_load  = 1'b1;
                            w_wdata = mem_out + DATA_W'(1);
                        end
                        OP_DEC: begin
                            w_load  = 1'b1;
                            w_wdata = mem_out - DATA_W'(1);
                        end
                        OP_CLR: begin
                            w_load  = 1'b1;
                        end
                        OP_RIGHT: w_ptr_nxt = r_ptr + ADDR_W'(1);
                        OP_LEFT:  w_ptr_nxt = r_ptr - ADDR_W'(1);
                        OP_OUT: begin
                            w_out_vld_nxt = 1'b1;
                            w_out_dat_nxt = mem_out;
                            w_state_nxt   = ST_WAIT_OUT;
                        end
                        OP_IN: begin
                            w_in_rdy_nxt = 1'b1;
                            w_state_nxt  = ST_WAIT_IN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_OUT: begin
                if (cmd_if.out_ready) begin
                    w_out_vld_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_IN: begin
                if (cmd_if.in_valid) begin
                    w_load       = 1'b1;
                    w_wdata      = cmd_if.in_data;
                    w_in_rdy_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign cmd_if.cmd_ready = w_cmd_rdy;
    assign cmd_if.out_valid = r_out_vld;
    assign cmd_if.out_data  = r_out_dat;
    assign cmd_if.in_ready  = r_in_rdy;

    assign busy              = w_busy;
    assign ptr               = r_ptr;
    assign cell_zero         = (mem_out == '0);
    assign mem_load          = w_load;
    assign mem_datain        = w_wdata;
    assign mem_write_address = w_waddr;
    assign mem_read_address  = r_ptr;

endmodule

// File: tb/tb_tape_controller.sv
// Directed bench for tape_controller with a behavioural 256x8 tape memory.
module tb_tape_controller;
    import tape_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] ptr;
    logic       cell_zero;
    logic       mem_load;
    logic [7:0] mem_datain;
    logic [7:0] mem_write_address;
    logic [7:0] mem_read_address;
    logic [7:0] mem_out;
    logic [7:0] tape [256];

    int total = 0;
    int bad   = 0;

    tape_controller_if #(.DATA_W(8)) cmd_if ();

    tape_controller #(.ADDR_W(8), .DATA_W(8), .CLEAR_ON_RESET(1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_if            (cmd_if),
        .busy              (busy),
        .ptr               (ptr),
        .cell_zero         (cell_zero),
        .mem_load          (mem_load),
        .mem_datain        (mem_datain),
        .mem_write_address (mem_write_address),
        .mem_read_address  (mem_read_address),
        .mem_out           (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_load) tape[mem_write_address] <= mem_datain;
    end
    assign mem_out = tape[mem_read_address];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        cmd_if.in_valid  = 1'b0;
        cmd_if.in_data   = 8'h00;
        cmd_if.out_ready = 1'b0;
        step(); step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
        total++; if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_if.cmd_ready); end
        total++; if (ptr !== 8'd0) begin bad++; $display("FAIL rst_ptr got=%0d exp=0", ptr); end
        total++; if (cmd_if.out_valid !== 1'b0 || cmd_if.in_ready !== 1'b0 || cmd_if.out_data !== 8'h00) begin
            bad++; $display("FAIL rst_streams got ov=%b ir=%b od=%h exp 0/0/00", cmd_if.out_valid, cmd_if.in_ready, cmd_if.out_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0 || mem_load !== 1'b1 ||
                mem_write_address !== 8'(i) || mem_datain !== 8'h00) begin
                bad++;
                $display("FAIL clear_cycle%0d got busy=%b rdy=%b ld=%b wa=%0d wd=%h exp 1/0/1/%0d/00",
                         i, busy, cmd_if.cmd_ready, mem_load, mem_write_address, mem_datain, i);
            end
            step();
        end
        total++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || mem_load !== 1'b0) begin
            bad++; $display("FAIL clear_done got busy=%b rdy=%b ld=%b exp 0/1/0", busy, cmd_if.cmd_ready, mem_load);
        end
        total++; if (ptr !== 8'd0 || cell_zero !== 1'b1) begin
            bad++; $display("FAIL clear_ptr_zero got ptr=%0d cz=%b exp 0/1", ptr, cell_zero);
        end
    endtask

    task automatic test_back_to_back();
        op_e        ops [6];
        logic [7:0] wd  [6];
        logic       ld  [6];
        ops = '{OP_INC, OP_INC, OP_INC, OP_RIGHT, OP_DEC, OP_LEFT};
        wd  = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd255, 8'd0};
        ld  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = ops[i];
            #1;
            total++;
            if (cmd_if.cmd_ready !== 1'b1 || mem_load !== ld[i] || (ld[i] && mem_datain !== wd[i])) begin
                bad++;
                $display("FAIL b2b_cmd%0d got rdy=%b ld=%b wd=%0d exp 1/%b/%0d",
                         i, cmd_if.cmd_ready, mem_load, mem_datain, ld[i], wd[i]);
            end
            step();
        end
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        #1;
        total++; if (tape[0] !== 8'd3) begin bad++; $display("FAIL b2b_cell0 got=%0d exp=3", tape[0]); end
        total++; if (tape[1] !== 8'd255) begin bad++; $display("FAIL b2b_cell1 got=%0d exp=255", tape[1]); end
        total++; if (ptr !== 8'd0 || cell_zero !== 1'b0 || mem_out !== 8'd3) begin
            bad++; $display("FAIL b2b_ptr got ptr=%0d cz=%b mo=%0d exp 0/0/3", ptr, cell_zero, mem_out);
        end
        step();
    endtask

    task automatic test_wrap();
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_LEFT; step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (ptr !== 8'd255 || mem_read_address !== 8'd255) begin
            bad++; $display("FAIL wrap_left got ptr=%0d ra=%0d exp 255", ptr, mem_read_address);
        end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_DEC; step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (mem_out !== 8'd255 || cell_zero !== 1'b0) begin
            bad++; $display("FAIL wrap_dec got mo=%0d cz=%b exp 255/0", mem_out, cell_zero);
        end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_INC; step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (mem_out !== 8'd0 || cell_zero !== 1'b1) begin
            bad++; $display("FAIL wrap_inc got mo=%0d cz=%b exp 0/1", mem_out, cell_zero);
        end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_RIGHT; step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (ptr !== 8'd0) begin bad++; $display("FAIL wrap_right got ptr=%0d exp 0", ptr); end
    endtask

    task automatic test_out();
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_CLR; step();
        total++; if (cell_zero !== 1'b1 || tape[0] !== 8'd0) begin
            bad++; $display("FAIL clr_cell got cz=%b cell=%0d exp 1/0", cell_zero, tape[0]);
        end
        cmd_if.cmd_op = OP_INC;
        for (int i = 0; i < 8'h41; i++) step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (mem_out !== 8'h41) begin bad++; $display("FAIL out_setup got=%h exp=41", mem_out); end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_OUT;
        #1;
        total++; if (cmd_if.out_valid !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL out_accept got ov=%b rdy=%b exp 0/1", cmd_if.out_valid, cmd_if.cmd_ready);
        end
        step();
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (cmd_if.out_valid !== 1'b1 || cmd_if.out_data !== 8'h41 || cmd_if.cmd_ready !== 1'b0 || mem_load !== 1'b0) begin
                bad++;
                $display("FAIL out_hold%0d got ov=%b od=%h rdy=%b ld=%b exp 1/41/0/0",
                         i, cmd_if.out_valid, cmd_if.out_data, cmd_if.cmd_ready, mem_load);
            end
            step();
        end
        cmd_if.out_ready = 1'b1;
        step();
        cmd_if.out_ready = 1'b0;
        total++; if (cmd_if.out_valid !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL out_done got ov=%b rdy=%b exp 0/1", cmd_if.out_valid, cmd_if.cmd_ready);
        end
    endtask

    task automatic test_in();
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_RIGHT; step();
        cmd_if.cmd_op = OP_IN;
        #1;
        total++; if (cmd_if.in_ready !== 1'b0) begin bad++; $display("FAIL in_accept got ir=%b exp 0", cmd_if.in_ready); end
        step();
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cmd_if.in_ready !== 1'b1 || cmd_if.cmd_ready !== 1'b0 || mem_load !== 1'b0) begin
                bad++;
                $display("FAIL in_wait%0d got ir=%b rdy=%b ld=%b exp 1/0/0", i, cmd_if.in_ready, cmd_if.cmd_ready, mem_load);
            end
            step();
        end
        cmd_if.in_valid = 1'b1; cmd_if.in_data = 8'h7F;
        #1;
        total++; if (mem_load !== 1'b1 || mem_write_address !== 8'd1 || mem_datain !== 8'h7F) begin
            bad++; $display("FAIL in_write got ld=%b wa=%0d wd=%h exp 1/1/7f", mem_load, mem_write_address, mem_datain);
        end
        step();
        cmd_if.in_valid = 1'b0; cmd_if.in_data = 8'h00;
        #1;
        total++; if (cmd_if.in_ready !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || mem_load !== 1'b0) begin
            bad++; $display("FAIL in_done got ir=%b rdy=%b ld=%b exp 0/1/0", cmd_if.in_ready, cmd_if.cmd_ready, mem_load);
        end
        total++; if (mem_out !== 8'h7F || cell_zero !== 1'b0) begin
            bad++; $display("FAIL in_cell got mo=%h cz=%b exp 7f/0", mem_out, cell_zero);
        end
        step();
    endtask

    task automatic test_reset_mid();
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_IN; step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (cmd_if.in_ready !== 1'b1 || ptr !== 8'd1) begin
            bad++; $display("FAIL mid_in_setup got ir=%b ptr=%0d exp 1/1", cmd_if.in_ready, ptr);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (cmd_if.in_ready !== 1'b0 || ptr !== 8'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_in_abort got ir=%b ptr=%0d busy=%b exp 0/0/1", cmd_if.in_ready, ptr, busy);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step();
        total++; if (mem_write_address !== 8'd100 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_clr_addr got wa=%0d busy=%b exp 100/1", mem_write_address, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem_write_address !== 8'd0 || busy !== 1'b1 || ptr !== 8'd0) begin
            bad++; $display("FAIL mid_clr_abort got wa=%0d busy=%b ptr=%0d exp 0/1/0", mem_write_address, busy, ptr);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (busy !== 1'b1 || mem_load !== 1'b1 || mem_write_address !== 8'(i)) begin
                bad++;
                $display("FAIL reclear_cycle%0d got busy=%b ld=%b wa=%0d exp 1/1/%0d", i, busy, mem_load, mem_write_address, i);
            end
            step();
        end
        total++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || tape[1] !== 8'd0 || tape[0] !== 8'd0) begin
            bad++; $display("FAIL reclear_done got busy=%b rdy=%b c0=%h c1=%h exp 0/1/00/00", busy, cmd_if.cmd_ready, tape[0], tape[1]);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_out();
        test_in();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tape_controller.md
# tape_controller

Data-side initiator for the processor's 256-cell tape memory. Accepts one decoded data command per handshake (`+ - > < . ,` plus NOP and clear-cell), drives the tape memory's write port and read address, keeps the data pointer, and bridges `.`/`,` to byte-wide output/input streams. After reset it optionally zero-fills the whole tape, so tape contents never depend on simulation-only initialisation. It sits between the instruction sequencer (command source, consumer of `cell_zero` for bracket jumps) and the tape memory.

## Interface
- ADDR_W, 8, tape address width; tape depth is 2^ADDR_W.
- DATA_W, 8, cell width.
- CLEAR_ON_RESET, 1, zero-fill the tape after reset when 1.

- clk  in  1  clock; single clock domain, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  command opcode (`tape_pkg::op_e`).
- busy  out  1  tape clear in progress.
- ptr  out  ADDR_W  current data pointer.
- cell_zero  out  1  cell at `ptr` equals 0 (combinational from `mem_out`).
- mem_load  out  1  tape write enable.
- mem_datain  out  DATA_W  tape write data.
- mem_write_address  out  ADDR_W  tape write address.
- mem_read_address  out  ADDR_W  tape read address; always equals `ptr`.
- mem_out  in  DATA_W  tape read data, combinational from `mem_read_address`.
- in_valid / in_ready / in_data  in / out / in  1/1/DATA_W  input byte stream (`,`).
- out_valid / out_ready / out_data  out / in / out  1/1/DATA_W  output byte stream (`.`).

## Operation
- FSM states: CLEAR, IDLE, WAIT_OUT, WAIT_IN.
- Reset: state CLEAR (CLEAR_ON_RESET=1) or IDLE (=0); ptr=0, clear counter=0; out_valid=0, in_ready=0, out_data=0.
- CLEAR: mem_load=1, mem_write_address=counter, mem_datain=0, busy=1, cmd_ready=0; counter increments each cycle; after the write at address 2^ADDR_W-1 → IDLE. Exactly 2^ADDR_W write cycles.
- IDLE: cmd_ready=1. Accept = cmd_valid & cmd_ready.
  - INC / DEC: mem_load=1 in the accept cycle, mem_write_address=ptr, mem_datain=mem_out±1 modulo 2^DATA_W (255+1=0, 0−1=255).
  - CLR: mem_load=1, mem_datain=0.
  - RIGHT / LEFT: ptr±1 modulo 2^ADDR_W at the edge; no write.
  - NOP: no effect.
  - OUT: out_data←mem_out, out_valid←1 registered at the edge; → WAIT_OUT.
  - IN: in_ready←1 registered; → WAIT_IN.
- WAIT_OUT: cmd_ready=0; out_valid and out_data held stable until out_ready; on out_valid&out_ready, out_valid←0, → IDLE.
- WAIT_IN: cmd_ready=0; on in_valid&in_ready, mem_load=1, mem_datain=in_data, mem_write_address=ptr in that cycle; in_ready←0, → IDLE.
- mem_load is 0 in every cycle not listed above.
- Undefined opcode values are treated as NOP.

## Timing
- INC/DEC/CLR/RIGHT/LEFT/NOP: 1-cycle; next command acceptable in the following cycle, and cell_zero/mem_out reflect the update there (write-then-read, no forwarding needed).
- Back-to-back INC on the same cell each cycle must accumulate.
- OUT: out_valid rises the cycle after acceptance; cmd_ready returns the cycle after the out handshake.
- IN: in_ready rises the cycle after acceptance; the cell holds in_data and cmd_ready=1 the cycle after the in handshake.
- in_valid or out_ready asserted early (before WAIT_*) is ignored.
- rst_n asserted mid-clear or mid-wait: immediate abort, all state to reset values, clear restarts from address 0 after deassertion.

## Structure
- `tape_pkg`: `op_e` (INC=0, DEC=1, RIGHT=2, LEFT=3, OUT=4, IN=5, NOP=6, CLR=7), `state_e`, default ADDR_W/DATA_W.
- Single module; no sub-module. The bench instantiates it with the existing tape memory.

## Test plan
- Reset, CLEAR_ON_RESET=1 -> busy=1 and cmd_ready=0 for exactly 256 cycles, mem_load high each cycle with addresses 0..255 and data 0; then cmd_ready=1, ptr=0, cell_zero=1.
- INC×3, RIGHT, DEC, LEFT back-to-back -> cell0=3, cell1=255, ptr=0, cell_zero=0; each command accepted in one cycle.
- LEFT from ptr=0 -> ptr=255; RIGHT from 255 -> ptr=0; INC on 255-valued cell -> 0, cell_zero=1.
- Cell0=0x41, OUT with out_ready low 5 cycles -> out_valid=1, out_data=0x41 stable, cmd_ready=0; out_ready high -> one transfer, cmd_ready=1 next cycle.
- IN, in_valid delayed 3 cycles with in_data=0x7F -> in_ready high while waiting, single write of 0x7F to ptr, cell_zero=0.
- rst_n pulsed low mid-WAIT_IN and mid-CLEAR (address 100) -> in_ready=0 and ptr=0 at once; clear restarts at 0 and runs 256 cycles.
